// File: rtl/switch_debounce_port_pkg.sv
// rtl/switch_debounce_port_pkg.sv - I/O map addresses and prescaler divide helper for the switch input stage
package switch_debounce_port_pkg;

    localparam logic [7:0] DATA_PORT_ADDR   = 8'h00;
    localparam logic [7:0] CHANGE_PORT_ADDR = 8'h01;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/switch_debounce_port_debounce_cell.sv
// rtl/switch_debounce_port_debounce_cell.sv - one-bit sample history, stable level and toggle pulse
module debounce_cell #(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sample,
    output logic level,
    output logic toggle
);

    logic [STABLE_SAMPLES-1:0] hist;
    logic [STABLE_SAMPLES-1:0] hist_next;
    logic                      all_ones;
    logic                      all_zeros;

    // The acceptance decision includes the sample being shifted in on this tick.
    always_comb begin
        hist_next = {hist[STABLE_SAMPLES-2:0], sample};
        all_ones  = &hist_next;
        all_zeros = ~|hist_next;
        toggle    = tick && ((all_ones && !level) || (all_zeros && level));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist  <= '0;
            level <= 1'b0;
        end else begin
            if (tick) begin
                hist <= hist_next;
            end
            if (toggle) begin
                level <= ~level;
            end
        end
    end

endmodule

// File: rtl/switch_debounce_port.sv
// rtl/switch_debounce_port.sv - synchronised, debounced switch input port with sticky change flags and irq
module switch_debounce_port
    import switch_debounce_port_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50000000,
    parameter int unsigned SAMPLE_HZ      = 1000,
    parameter int          STABLE_SAMPLES = 4,
    parameter int          WIDTH          = 8,
    parameter logic [7:0]  CHANGE_PORT    = CHANGE_PORT_ADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [7:0]       port_id,
    input  logic             read_strobe,
    input  logic             interrupt_ack,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] change_flags,
    output logic             irq
);

    localparam int unsigned        DIV     = calc_div(CLK_FREQ_HZ, SAMPLE_HZ);
    localparam int                 CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DIV - 1);

    logic [WIDTH-1:0] sync_a;
    logic [WIDTH-1:0] sync_q;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [WIDTH-1:0] toggle;
    logic             read_clr;
    logic             set_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_q <= '0;
        end else begin
            sync_a <= raw_in;
            sync_q <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        debounce_cell #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .sample (sync_q[i]),
            .level  (data_out[i]),
            .toggle (toggle[i])
        );
    end

    assign read_clr = read_strobe && (port_id == CHANGE_PORT);

    // New toggles are OR-ed in after the read-clear so an event on the clearing edge survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            change_flags <= '0;
            set_pend     <= 1'b0;
            irq          <= 1'b0;
        end else begin
            change_flags <= (read_clr ? '0 : change_flags) | toggle;
            set_pend     <= |toggle;
            irq          <= set_pend | (irq & ~interrupt_ack);
        end
    end

endmodule

// File: tb/tb_switch_debounce_port.sv
// tb/tb_switch_debounce_port.sv - directed self-checking bench for switch_debounce_port
module tb_switch_debounce_port;

    logic       clk;
    logic       reset;
    logic [7:0] raw_in;
    logic [7:0] port_id;
    logic       read_strobe;
    logic       interrupt_ack;
    logic [7:0] data_out;
    logic [7:0] change_flags;
    logic       irq;

    int n_checks;
    int n_fail;
    int cyc;

    switch_debounce_port #(
        .CLK_FREQ_HZ    (100),
        .SAMPLE_HZ      (10),
        .STABLE_SAMPLES (4),
        .WIDTH          (8),
        .CHANGE_PORT    (8'h01)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .raw_in        (raw_in),
        .port_id       (port_id),
        .read_strobe   (read_strobe),
        .interrupt_ack (interrupt_ack),
        .data_out      (data_out),
        .change_flags  (change_flags),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Tick edges fall on every 10th edge after reset release.
    task automatic align_tick();
        for (int k = 0; k < 10 && (cyc % 10) != 0; k++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; raw_in = 8'h00; port_id = 8'h00; read_strobe = 1'b0; interrupt_ack = 1'b0;
        steps(3);
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        n_checks++;
        if (change_flags !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %h expected 00", change_flags); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_first_accept();
        raw_in = 8'h01;
        steps(39);
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL accept_early: got %h expected 00", data_out); end
        step();
        n_checks++;
        if (data_out !== 8'h01) begin n_fail++; $display("FAIL accept_data: got %h expected 01", data_out); end
        n_checks++;
        if (change_flags !== 8'h01) begin n_fail++; $display("FAIL accept_flags: got %h expected 01", change_flags); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL accept_irq_early: got %b expected 0", irq); end
        step();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL accept_irq: got %b expected 1", irq); end
    endtask

    task automatic test_short_pulse();
        raw_in = 8'h09;
        steps(25);
        raw_in = 8'h01;
        steps(60);
        n_checks++;
        if (data_out !== 8'h01) begin n_fail++; $display("FAIL pulse_data: got %h expected 01", data_out); end
        n_checks++;
        if (change_flags !== 8'h01) begin n_fail++; $display("FAIL pulse_flags: got %h expected 01", change_flags); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL pulse_irq: got %b expected 1", irq); end
    endtask

    task automatic test_read_clear_ack();
        port_id = 8'h00; read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
        n_checks++;
        if (change_flags !== 8'h01) begin n_fail++; $display("FAIL wrong_port_read: got %h expected 01", change_flags); end
        port_id = 8'h01; read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
        n_checks++;
        if (change_flags !== 8'h00) begin n_fail++; $display("FAIL read_clear_flags: got %h expected 00", change_flags); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL read_keeps_irq: got %b expected 1", irq); end
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL ack_irq: got %b expected 0", irq); end
    endtask

    task automatic test_set_over_clear();
        align_tick();
        raw_in = 8'h21;
        steps(39);
        n_checks++;
        if (data_out !== 8'h01) begin n_fail++; $display("FAIL b5_early: got %h expected 01", data_out); end
        port_id = 8'h01; read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
        n_checks++;
        if (data_out !== 8'h21) begin n_fail++; $display("FAIL b5_data: got %h expected 21", data_out); end
        n_checks++;
        if (change_flags !== 8'h20) begin n_fail++; $display("FAIL b5_set_wins: got %h expected 20", change_flags); end
        step();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL b5_irq: got %b expected 1", irq); end
    endtask

    task automatic test_mid_reset();
        int ticks_seen;
        ticks_seen = 0;
        raw_in = 8'hFF;
        for (int k = 0; k < 40 && ticks_seen < 2; k++) begin
            step();
            if ((cyc % 10) == 0) ticks_seen++;
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", data_out); end
        n_checks++;
        if (change_flags !== 8'h00) begin n_fail++; $display("FAIL midrst_flags: got %h expected 00", change_flags); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b expected 0", irq); end
        steps(2);
        reset = 1'b0;
        cyc = 0;
        steps(39);
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL post_rst_early: got %h expected 00", data_out); end
        step();
        n_checks++;
        if (data_out !== 8'hFF) begin n_fail++; $display("FAIL post_rst_data: got %h expected ff", data_out); end
        n_checks++;
        if (change_flags !== 8'hFF) begin n_fail++; $display("FAIL post_rst_flags: got %h expected ff", change_flags); end
        step();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL post_rst_irq: got %b expected 1", irq); end
    endtask

    task automatic test_release();
        port_id = 8'h01; read_strobe = 1'b1;
        step();
        read_strobe = 1'b0; interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        n_checks++;
        if (change_flags !== 8'h00 || irq !== 1'b0) begin
            n_fail++; $display("FAIL release_prep: got flags %h irq %b expected 00 0", change_flags, irq);
        end
        align_tick();
        raw_in = 8'hFE;
        steps(39);
        n_checks++;
        if (data_out !== 8'hFF) begin n_fail++; $display("FAIL release_early: got %h expected ff", data_out); end
        step();
        n_checks++;
        if (data_out !== 8'hFE) begin n_fail++; $display("FAIL release_data: got %h expected fe", data_out); end
        n_checks++;
        if (change_flags !== 8'h01) begin n_fail++; $display("FAIL release_flags: got %h expected 01", change_flags); end
        step();
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL release_irq: got %b expected 1", irq); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        test_reset();
        test_first_accept();
        test_short_pulse();
        test_read_clear_ack();
        test_set_over_clear();
        test_mid_reset();
        test_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
